// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with sub-word load extension and read-modify-write stores
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req_valid/req_ready   request handshake; one request in flight at a time
//   req_is_store          1 = store, 0 = load
//   req_funct3            RV32I width/sign code (B, H, W, BU, HU)
//   req_addr, req_wdata   byte address and store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load result (0 for stores and errors)
//   resp_error            misaligned, illegal funct3 or out-of-bounds
//   mem_*                 word-indexed memory port; read is combinational, write is whole-word
//
// Build option: define LSU_BOUNDS_CHECK_EN to flag word indices >= MEM_WORDS as errors.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;
  state_t state, state_d;
  logic [31:0] addr_q, merged_q, rdata_q, ld_val, merged_d;
  logic [15:0] wdata_q, rhalf;
  logic [7:0]  rbyte;
  logic [4:0]  sh;
  logic [2:0]  f3_q;
  logic        err_q, req_err, bad_f3, misalign, oob;
  assign bad_f3   = req_funct3 inside {3'b011, 3'b110, 3'b111} || (req_is_store && req_funct3[2]);
  assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
  assign oob      = BOUNDS_EN && ({2'b00, req_addr[31:2]} >= MEM_WORDS);
  assign req_err  = bad_f3 || misalign || oob;
  assign sh    = {addr_q[1:0], 3'b000};
  assign rbyte = 8'(mem_read_data >> sh);
  assign rhalf = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
  // funct3[2] selects zero extension; funct3[1] marks a full word
  assign ld_val = f3_q[1] ? mem_read_data :
                  f3_q[0] ? {{16{~f3_q[2] & rhalf[15]}}, rhalf} :
                            {{24{~f3_q[2] & rbyte[7]}}, rbyte};
  assign merged_d = f3_q[0] ?
    (mem_read_data & ~(32'h0000_FFFF << {addr_q[1], 4'b0000})) | ({16'h0, wdata_q} << {addr_q[1], 4'b0000}) :
    (mem_read_data & ~(32'h0000_00FF << sh)) | ({24'h0, wdata_q[7:0]} << sh);
  always_comb begin
    state_d          = state;
    req_ready        = state == IDLE;
    resp_valid       = state == RESP;
    resp_rdata       = state == RESP ? rdata_q : 32'h0;
    resp_error       = state == RESP && err_q;
    mem_addr         = state inside {LOAD, MERGE, WRITE} ? {2'b00, addr_q[31:2]} : 32'h0;
    mem_write_data   = state == WRITE ? merged_q : 32'h0;
    mem_write_enable = state == WRITE && !reset;
    case (state)
      IDLE:    if (req_valid) state_d = req_err ? RESP : !req_is_store ? LOAD : req_funct3 == 3'b010 ? WRITE : MERGE;
      LOAD:    state_d = RESP;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && req_valid) begin
        addr_q   <= req_addr;
        f3_q     <= req_funct3;
        wdata_q  <= req_wdata[15:0];
        merged_q <= req_wdata;
        rdata_q  <= '0;
        err_q    <= req_err;
      end
      if (state == LOAD) rdata_q <= ld_val;
      if (state == MERGE) merged_q <= merged_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [31:0] mem [0:63];
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  int lat;
  logic [31:0] rd;
  logic        er;
  logic [31:0] seen_addr;
  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );
  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_addr[5:0]] <= mem_write_data;
      we_cnt <= we_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_write_data;
    end
  end
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_is_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    lat = 0;
    seen_addr = '0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (lat == 1) seen_addr = mem_addr;
    end while (!resp_valid && lat < 8);
    rd = resp_rdata;
    er = resp_error;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_resp got v=%b e=%b d=%h want 0", resp_valid, resp_error, resp_rdata); end
    tests++; if (mem_write_enable !== 1'b0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin fails++; $display("FAIL reset_mem got we=%b a=%h d=%h want 0", mem_write_enable, mem_addr, mem_write_data); end
    reset = 1'b0;
  endtask
  task automatic test_sw_lw();
    int w0;
    w0 = we_cnt;
    issue(1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
    tests++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got %0d want 2", lat); end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL resp_ready got %b want 0", req_ready); end
    @(negedge clk);
    tests++; if (we_cnt - w0 !== 1 || last_waddr !== 32'd2 || last_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_write got n=%0d a=%h d=%h want 1 2 deadbeef", we_cnt - w0, last_waddr, last_wdata); end
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL resp_pulse got v=%b r=%b want 0 1", resp_valid, req_ready); end
    issue(1'b0, 3'b010, 32'h08, 32'h0);
    tests++; if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL lw got lat=%0d d=%h e=%b want 2 deadbeef 0", lat, rd, er); end
  endtask
  task automatic test_sub_store();
    issue(1'b1, 3'b010, 32'h08, 32'h11223344);
    issue(1'b1, 3'b000, 32'h0A, 32'h000000AA);
    tests++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL sb_resp got lat=%0d e=%b d=%h want 3 0 0", lat, er, rd); end
    @(negedge clk);
    tests++; if (last_wdata !== 32'h11AA3344 || last_waddr !== 32'd2) begin fails++; $display("FAIL sb_merge got a=%h d=%h want 2 11aa3344", last_waddr, last_wdata); end
    issue(1'b1, 3'b001, 32'h08, 32'hFFFF5566);
    issue(1'b0, 3'b010, 32'h08, 32'h0);
    tests++; if (rd !== 32'h11AA5566) begin fails++; $display("FAIL sh_merge got %h want 11aa5566", rd); end
  endtask
  task automatic test_loads();
    issue(1'b1, 3'b010, 32'h08, 32'h80FF7F01);
    issue(1'b0, 3'b000, 32'h0B, 32'h0);
    tests++; if (rd !== 32'hFFFFFF80 || lat !== 2) begin fails++; $display("FAIL lb got %h lat=%0d want ffffff80 2", rd, lat); end
    issue(1'b0, 3'b100, 32'h0B, 32'h0);
    tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu got %h want 00000080", rd); end
    issue(1'b0, 3'b001, 32'h08, 32'h0);
    tests++; if (rd !== 32'h00007F01) begin fails++; $display("FAIL lh got %h want 00007f01", rd); end
    issue(1'b0, 3'b101, 32'h0A, 32'h0);
    tests++; if (rd !== 32'h000080FF) begin fails++; $display("FAIL lhu got %h want 000080ff", rd); end
    issue(1'b0, 3'b001, 32'h0A, 32'h0);
    tests++; if (rd !== 32'hFFFF80FF) begin fails++; $display("FAIL lh_hi got %h want ffff80ff", rd); end
    issue(1'b0, 3'b000, 32'h09, 32'h0);
    tests++; if (rd !== 32'h0000007F) begin fails++; $display("FAIL lb_pos got %h want 0000007f", rd); end
  endtask
  task automatic test_errors();
    int w0;
    w0 = we_cnt;
    issue(1'b0, 3'b010, 32'h06, 32'h0);
    tests++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin fails++; $display("FAIL lw_misalign got e=%b lat=%0d d=%h want 1 1 0", er, lat, rd); end
    issue(1'b1, 3'b001, 32'h09, 32'h1234);
    tests++; if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin fails++; $display("FAIL sh_misalign got e=%b lat=%0d d=%h want 1 1 0", er, lat, rd); end
    issue(1'b0, 3'b011, 32'h08, 32'h0);
    tests++; if (er !== 1'b1 || lat !== 1) begin fails++; $display("FAIL bad_f3_load got e=%b lat=%0d want 1 1", er, lat); end
    issue(1'b1, 3'b110, 32'h08, 32'h0);
    tests++; if (er !== 1'b1 || lat !== 1) begin fails++; $display("FAIL bad_f3_store got e=%b lat=%0d want 1 1", er, lat); end
    @(negedge clk);
    tests++; if (we_cnt !== w0) begin fails++; $display("FAIL err_no_write got %0d writes want 0", we_cnt - w0); end
    issue(1'b0, 3'b010, 32'h08, 32'h0);
    tests++; if (rd !== 32'h80FF7F01 || er !== 1'b0) begin fails++; $display("FAIL err_mem_intact got %h e=%b want 80ff7f01 0", rd, er); end
  endtask
  task automatic test_reset_mid();
    int w0;
    issue(1'b1, 3'b010, 32'h0C, 32'h55667788);
    w0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_is_store = 1'b1;
    req_funct3 = 3'b001;
    req_addr = 32'h0C;
    req_wdata = 32'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests++; if (mem_addr !== 32'd3) begin fails++; $display("FAIL mid_write_addr got %h want 3", mem_addr); end
    reset = 1'b1;
    #1;
    tests++; if (mem_write_enable !== 1'b0) begin fails++; $display("FAIL reset_gates_we got %b want 0", mem_write_enable); end
    @(negedge clk);
    reset = 1'b0;
    tests++; if (we_cnt !== w0) begin fails++; $display("FAIL reset_no_write got %0d writes want 0", we_cnt - w0); end
    tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin fails++; $display("FAIL reset_mid_outputs got r=%b v=%b d=%h a=%h wd=%h want 1 0 0 0 0", req_ready, resp_valid, resp_rdata, mem_addr, mem_write_data); end
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    tests++; if (rd !== 32'h55667788) begin fails++; $display("FAIL word3_unchanged got %h want 55667788", rd); end
  endtask
  task automatic test_bounds();
    issue(1'b0, 3'b010, 32'h80, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    tests++; if (er !== 1'b1 || lat !== 1) begin fails++; $display("FAIL bounds_err got e=%b lat=%0d want 1 1", er, lat); end
`else
    tests++; if (er !== 1'b0 || lat !== 2 || seen_addr !== 32'd32) begin fails++; $display("FAIL bounds_pass got e=%b lat=%0d a=%h want 0 2 20", er, lat, seen_addr); end
`endif
  endtask
  initial begin
    test_reset();
    test_sw_lw();
    test_sub_store();
    test_loads();
    test_errors();
    test_reset_mid();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
